// File: rtl/main_mem_responder.sv
// main_mem_responder: burst-bus memory responder over an on-chip word array.
// Optional ADDR_CHECK_EN macro enables out-of-range detection (w_err) instead of index wrap-around.
module main_mem_responder #(
  parameter int MAIN_MEM_ADDR_WIDTH = 32,
  parameter int BURST_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter logic [MAIN_MEM_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                           w_clock,
  input  logic                           w_reset,
  input  logic [BURST_WIDTH-1:0]         w_burst,
  input  logic [MAIN_MEM_ADDR_WIDTH-1:0] w_addr,
  input  logic                           w_rw,
  input  logic [DATA_WIDTH-1:0]          w_wdata,
  output logic [DATA_WIDTH-1:0]          w_rdata,
  output logic                           w_rvalid,
  output logic                           w_busy,
  output logic                           w_done,
  output logic                           w_err
);
  typedef enum logic {IDLE, BEAT} state_t;
  state_t state_q, state_d;
  logic [BURST_WIDTH-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic rvalid_q, rvalid_d, done_q, done_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic [MAIN_MEM_ADDR_WIDTH-1:0] idx_full;
  logic [DEPTH_LOG2-1:0] idx;
  logic oor, beat, last;
  assign idx_full = w_addr - BASE_ADDR;
  assign idx = idx_full[DEPTH_LOG2-1:0];
`ifdef ADDR_CHECK_EN
  assign oor = |(idx_full >> DEPTH_LOG2);
`else
  logic unused_hi;
  assign unused_hi = ^idx_full[MAIN_MEM_ADDR_WIDTH-1:DEPTH_LOG2];
  assign oor = 1'b0;
`endif
  assign beat = state_q == BEAT;
  assign last = beat && cnt_q == len_q - 1'b1;
  always_ff @(posedge w_clock or posedge w_reset)
    if (w_reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  always_comb begin
    state_d = beat ? (last ? IDLE : BEAT) : (w_burst != '0 ? BEAT : IDLE);
    len_d = (!beat && w_burst != '0) ? w_burst : len_q;
    cnt_d = (beat && !last) ? cnt_q + 1'b1 : '0;
  end
  // Write lands at the beat edge, so a read in the next beat already sees it.
  always_comb begin
    done_d = last;
    rvalid_d = beat && w_rw;
    rdata_d = rvalid_d ? (oor ? '0 : mem[idx]) : rdata_q;
    err_d = err_q || (beat && oor);
  end
  always_ff @(posedge w_clock)
    if (beat && !w_rw && !oor) mem[idx] <= w_wdata;
  always_comb begin
    w_busy = state_q == BEAT;
    w_rdata = rdata_q;
    w_rvalid = rvalid_q;
    w_done = done_q;
    w_err = err_q;
  end
endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: directed checks of burst sequencing, read/write data, reset and address range.
module tb_main_mem_responder;
  logic clk = 1'b0, rst = 1'b1, rw = 1'b0;
  logic [5:0] burst = '0;
  logic [31:0] addr = '0;
  logic [15:0] wdata = '0, rdata;
  logic rvalid, busy, done, err;
  int tests = 0, failed = 0;
  main_mem_responder dut (
    .w_clock(clk), .w_reset(rst), .w_burst(burst), .w_addr(addr), .w_rw(rw),
    .w_wdata(wdata), .w_rdata(rdata), .w_rvalid(rvalid), .w_busy(busy),
    .w_done(done), .w_err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic [5:0] b, input logic [31:0] a, input logic r, input logic [15:0] d);
    burst = b; addr = a; rw = r; wdata = d;
    @(posedge clk); #1;
  endtask
  task automatic chk_all(input string tag, input logic [15:0] rd, input logic rv, input logic bz, input logic dn, input logic er);
    chk({tag, ".rdata"}, rdata, rd);
    chk({tag, ".rvalid"}, rvalid, rv);
    chk({tag, ".busy"}, busy, bz);
    chk({tag, ".done"}, done, dn);
    chk({tag, ".err"}, err, er);
  endtask
  logic chk_en;
  initial begin
`ifdef ADDR_CHECK_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
    @(posedge clk); @(posedge clk); #1;
    chk_all("reset", 16'h0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0);
    chk_all("idle_zero_burst", 16'h0, 0, 0, 0, 0);
    cyc(4, 0, 0, 0);
    chk_all("wr_hdr", 16'h0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, i, 0, 16'hA0 + 16'(i));
      chk_all($sformatf("wr_beat%0d", i), 16'h0, 0, i < 3, i == 3, 0);
    end
    cyc(4, 0, 0, 0);
    chk_all("rd_hdr_b2b", 16'h0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(6'h3f, i, 1, 0);
      chk_all($sformatf("rd_beat%0d", i), 16'hA0 + 16'(i), 1, i < 3, i == 3, 0);
    end
    cyc(0, 0, 0, 0);
    chk_all("rd_hold", 16'hA3, 0, 0, 0, 0);
    cyc(16, 0, 0, 0);
    chk("b16_hdr.busy", busy, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(16, 100 + i, 0, 16'h100 + 16'(i));
      chk($sformatf("b16_beat%0d.busy", i), busy, i < 15);
      chk($sformatf("b16_beat%0d.done", i), done, i == 15);
    end
    cyc(0, 0, 0, 0);
    chk_all("b16_after", 16'hA3, 0, 0, 0, 0);
    cyc(3, 0, 0, 0);
    cyc(0, 100, 1, 0);
    chk("b16_rd100", rdata, 16'h100);
    cyc(0, 115, 0, 16'h1FF);
    cyc(0, 115, 1, 0);
    chk("raw_same_addr", rdata, 16'h1FF);
    chk("raw_done", done, 1);
    cyc(8, 0, 0, 0);
    cyc(8, 200, 0, 16'hC0);
    cyc(8, 201, 0, 16'hC1);
    burst = 8; addr = 0; rw = 0; wdata = 16'hDEAD;
    #2 rst = 1'b1;
    #1 chk_all("mid_reset", 16'h0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_all("mid_reset_held", 16'h0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(2, 0, 0, 0);
    chk("post_rst_hdr.busy", busy, 1);
    cyc(0, 0, 1, 0);
    chk("post_rst_rd0", rdata, 16'hA0);
    cyc(0, 200, 1, 0);
    chk("post_rst_rd200", rdata, 16'hC0);
    chk("post_rst_done", done, 1);
    cyc(3, 0, 0, 0);
    cyc(0, 1024, 0, 16'h55);
    chk("oor_wr.err", err, chk_en);
    cyc(0, 1024, 1, 0);
    chk("oor_rd1024", rdata, chk_en ? 16'h0 : 16'h55);
    chk("oor_rd1024.rvalid", rvalid, 1);
    cyc(0, 0, 1, 0);
    chk("oor_rd0", rdata, chk_en ? 16'hA0 : 16'h55);
    chk("oor_err_sticky", err, chk_en);
    cyc(0, 0, 0, 0);
    chk("oor_err_hold", err, chk_en);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
